alu_result_collector: RTL and testbench
=======================================

ALU_RESULT_COLLECTOR -- requirements
Module: alu_result_collector

Interface
REQ-001 Parameter ARITH_WIDTH, default 32, arithmetic result width and RES_DATA width.
REQ-002 Parameter LOGIC_WIDTH, default 16, logic result width.
REQ-003 Parameter CMP_WIDTH, default 16, compare result width.
REQ-004 Parameter SHIFT_WIDTH, default 16, shift result width.
REQ-005 Parameter DEPTH, default 4, result queue entries (power of two, >= 2).
REQ-006 CLK  input  1  sole clock, rising edge.
REQ-007 RST  input  1  asynchronous, active-high reset.
REQ-008 Arith_OUT  input  ARITH_WIDTH  arithmetic unit result.
REQ-009 Carry_OUT  input  1  arithmetic carry.
REQ-010 Logic_OUT  input  LOGIC_WIDTH  logic unit result.
REQ-011 CMP_OUT  input  CMP_WIDTH  compare unit result.
REQ-012 Shift_OUT  input  SHIFT_WIDTH  shift unit result.
REQ-013 Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  input  1 each  per-unit result-valid.
REQ-014 CLR  input  1  synchronous flush of queue and sticky errors.
REQ-015 RES_READY  input  1  consumer accepts head entry.
REQ-016 RES_VALID  output  1  head entry present.
REQ-017 RES_DATA  output  ARITH_WIDTH  head result, narrower results zero-extended.
REQ-018 RES_TAG  output  2  source: 00 arith, 01 logic, 10 cmp, 11 shift.
REQ-019 RES_CARRY  output  1  head carry (0 for non-arith entries).
REQ-020 RES_COUNT  output  log2(DEPTH)+1  queued entries.
REQ-021 OVERFLOW  output  1  sticky: result dropped on full queue.
REQ-022 MULTI_ERR  output  1  sticky: more than one flag high in a cycle.

Function
REQ-023 Capture: each rising edge with exactly one flag high SHALL be a push of {tag, carry, zero-extended data}; a flag held high N cycles SHALL push N entries.
REQ-024 No flag high SHALL push nothing.
REQ-025 Two or more flags high SHALL push nothing and set MULTI_ERR.
REQ-026 Pop SHALL occur on a rising edge with RES_VALID=1 and RES_READY=1; head advances next cycle.
REQ-027 Queue SHALL be FIFO; entries delivered in capture order, none reordered or duplicated.
REQ-028 Latency: flag at edge k into empty queue SHALL give RES_VALID=1 with that entry after edge k (no combinational bypass).
REQ-029 RES_DATA/RES_TAG/RES_CARRY SHALL be stable while RES_VALID=1 and RES_READY=0.
REQ-030 RES_DATA/RES_TAG/RES_CARRY SHALL be 0 when RES_VALID=0.
REQ-031 Full, push, no pop: push dropped, OVERFLOW set, contents unchanged.
REQ-032 Full, push and pop same edge: both performed, RES_COUNT stays DEPTH, OVERFLOW unchanged.
REQ-033 Empty, RES_READY=1, no push: no effect; RES_COUNT never underflows.
REQ-034 Push and pop same edge, non-empty non-full: RES_COUNT unchanged.
REQ-035 Read/write pointers SHALL wrap modulo DEPTH; RES_COUNT SHALL equal entries queued.
REQ-036 CLR=1 SHALL empty queue, clear OVERFLOW and MULTI_ERR next edge; CLR has priority over push and pop that cycle.
REQ-037 OVERFLOW and MULTI_ERR SHALL stay set until CLR or RST.

Reset
REQ-038 RST=1 SHALL immediately force RES_VALID=0, RES_DATA=0, RES_TAG=0, RES_CARRY=0, RES_COUNT=0, OVERFLOW=0, MULTI_ERR=0, pointers 0.
REQ-039 RST asserted mid-operation SHALL discard all queued entries; first edge after release SHALL behave as from empty.
REQ-040 Flags seen while RST=1 SHALL not be captured.

Verification
REQ-041 Reset: RST pulse with queue holding 3 entries -> all outputs 0 asynchronously, RES_COUNT=0.
REQ-042 Single capture: Logic_Flag=1, Logic_OUT=16'hA5A5 one cycle, RES_READY=0 -> next cycle RES_VALID=1, RES_DATA=32'h0000A5A5, RES_TAG=01, RES_CARRY=0, RES_COUNT=1.
REQ-043 Order/wrap: push arith 32'h1 (carry 1), cmp 16'h3, shift 16'h8, logic 16'hF, arith 32'h5, popping one per cycle after 2 -> delivered in same order, tags 00,10,11,01,00, first RES_CARRY=1.
REQ-044 Overflow: DEPTH=4, 5 consecutive Shift_Flag cycles, RES_READY=0 -> RES_COUNT=4, OVERFLOW=1, head = first value; then push+pop on full -> RES_COUNT=4.
REQ-045 Multi-flag: Arith_Flag=1 and CMP_Flag=1 same cycle -> no push, MULTI_ERR=1 held until CLR; CLR -> RES_COUNT=0, MULTI_ERR=0, OVERFLOW=0.
REQ-046 Backpressure: 2 entries, RES_READY toggling 0/1 each cycle -> outputs stable while stalled, both entries popped exactly once.

Source files
------------

// File: rtl/alu_result_collector.sv
// Collects results from four ALU sub-units into an in-order queue for a single consumer.
// Output fields are registered and forced to zero whenever the queue is empty.
module alu_result_collector #(
  parameter int ARITH_WIDTH = 32,
  parameter int LOGIC_WIDTH = 16,
  parameter int CMP_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 16,
  parameter int DEPTH       = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [ARITH_WIDTH-1:0]       Arith_OUT,
  input  logic                         Carry_OUT,
  input  logic [LOGIC_WIDTH-1:0]       Logic_OUT,
  input  logic [CMP_WIDTH-1:0]         CMP_OUT,
  input  logic [SHIFT_WIDTH-1:0]       Shift_OUT,
  input  logic                         Arith_Flag,
  input  logic                         Logic_Flag,
  input  logic                         CMP_Flag,
  input  logic                         Shift_Flag,
  input  logic                         CLR,
  input  logic                         RES_READY,
  output logic                         RES_VALID,
  output logic [ARITH_WIDTH-1:0]       RES_DATA,
  output logic [1:0]                   RES_TAG,
  output logic                         RES_CARRY,
  output logic [$clog2(DEPTH):0]       RES_COUNT,
  output logic                         OVERFLOW,
  output logic                         MULTI_ERR
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [ARITH_WIDTH-1:0] mem_data_r  [DEPTH];
  logic [1:0]             mem_tag_r   [DEPTH];
  logic                   mem_carry_r [DEPTH];

  logic [PW-1:0]          wr_ptr_r;
  logic [PW-1:0]          rd_ptr_r;
  logic [PW-1:0]          nxt_rd_ptr_s;
  logic [CW-1:0]          count_r;
  logic [CW-1:0]          nxt_count_s;

  logic [2:0]             flag_cnt_s;
  logic                   single_s;
  logic                   multi_s;
  logic                   full_s;
  logic                   pop_s;
  logic                   push_s;
  logic                   drop_s;

  logic [ARITH_WIDTH-1:0] push_data_s;
  logic [1:0]             push_tag_s;
  logic                   push_carry_s;
  logic [ARITH_WIDTH-1:0] head_data_s;
  logic [1:0]             head_tag_s;
  logic                   head_carry_s;

  logic                   res_valid_r;
  logic [ARITH_WIDTH-1:0] res_data_r;
  logic [1:0]             res_tag_r;
  logic                   res_carry_r;
  logic                   overflow_r;
  logic                   multi_err_r;

  assign RES_VALID = res_valid_r;
  assign RES_DATA  = res_data_r;
  assign RES_TAG   = res_tag_r;
  assign RES_CARRY = res_carry_r;
  assign RES_COUNT = count_r;
  assign OVERFLOW  = overflow_r;
  assign MULTI_ERR = multi_err_r;

  // Select the captured word for the single active unit.
  always_comb begin
    flag_cnt_s   = 3'(Arith_Flag) + 3'(Logic_Flag) + 3'(CMP_Flag) + 3'(Shift_Flag);
    single_s     = (flag_cnt_s == 3'd1);
    multi_s      = (flag_cnt_s >= 3'd2);
    push_data_s  = {ARITH_WIDTH{1'b0}};
    push_tag_s   = 2'b00;
    push_carry_s = 1'b0;
    case ({Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag})
      4'b1000: begin
        push_data_s  = Arith_OUT;
        push_tag_s   = 2'b00;
        push_carry_s = Carry_OUT;
      end
      4'b0100: begin
        push_data_s = ARITH_WIDTH'(Logic_OUT);
        push_tag_s  = 2'b01;
      end
      4'b0010: begin
        push_data_s = ARITH_WIDTH'(CMP_OUT);
        push_tag_s  = 2'b10;
      end
      4'b0001: begin
        push_data_s = ARITH_WIDTH'(Shift_OUT);
        push_tag_s  = 2'b11;
      end
      default: begin
        push_data_s  = {ARITH_WIDTH{1'b0}};
        push_tag_s   = 2'b00;
        push_carry_s = 1'b0;
      end
    endcase
  end

  // Queue control and look-ahead of the next head so the outputs can be registered.
  always_comb begin
    full_s       = (count_r == FULL_COUNT);
    pop_s        = res_valid_r & RES_READY;
    push_s       = single_s & (~full_s | pop_s);
    drop_s       = single_s & full_s & ~pop_s;
    nxt_rd_ptr_s = rd_ptr_r;
    if (pop_s) begin
      nxt_rd_ptr_s = rd_ptr_r + 1'b1;
    end else begin
      nxt_rd_ptr_s = rd_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   nxt_count_s = count_r + 1'b1;
      2'b01:   nxt_count_s = count_r - 1'b1;
      default: nxt_count_s = count_r;
    endcase
    // A push landing on the next head slot must bypass the storage array.
    if (push_s && (wr_ptr_r == nxt_rd_ptr_s)) begin
      head_data_s  = push_data_s;
      head_tag_s   = push_tag_s;
      head_carry_s = push_carry_s;
    end else begin
      head_data_s  = mem_data_r[nxt_rd_ptr_s];
      head_tag_s   = mem_tag_r[nxt_rd_ptr_s];
      head_carry_s = mem_carry_r[nxt_rd_ptr_s];
    end
  end

  // Queue storage, pointers, sticky errors and registered head outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_r[i]  <= {ARITH_WIDTH{1'b0}};
        mem_tag_r[i]   <= 2'b00;
        mem_carry_r[i] <= 1'b0;
      end
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      overflow_r  <= 1'b0;
      multi_err_r <= 1'b0;
      res_valid_r <= 1'b0;
      res_data_r  <= {ARITH_WIDTH{1'b0}};
      res_tag_r   <= 2'b00;
      res_carry_r <= 1'b0;
    end else if (CLR) begin
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      overflow_r  <= 1'b0;
      multi_err_r <= 1'b0;
      res_valid_r <= 1'b0;
      res_data_r  <= {ARITH_WIDTH{1'b0}};
      res_tag_r   <= 2'b00;
      res_carry_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_data_r[wr_ptr_r]  <= push_data_s;
        mem_tag_r[wr_ptr_r]   <= push_tag_s;
        mem_carry_r[wr_ptr_r] <= push_carry_s;
        wr_ptr_r              <= wr_ptr_r + 1'b1;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r    <= nxt_rd_ptr_s;
      count_r     <= nxt_count_s;
      overflow_r  <= overflow_r | drop_s;
      multi_err_r <= multi_err_r | multi_s;
      if (nxt_count_s != {CW{1'b0}}) begin
        res_valid_r <= 1'b1;
        res_data_r  <= head_data_s;
        res_tag_r   <= head_tag_s;
        res_carry_r <= head_carry_s;
      end else begin
        res_valid_r <= 1'b0;
        res_data_r  <= {ARITH_WIDTH{1'b0}};
        res_tag_r   <= 2'b00;
        res_carry_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed bench for alu_result_collector: reset, capture, ordering, overflow, multi-flag, backpressure.
module tb_alu_result_collector;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Arith_OUT;
  logic        Carry_OUT;
  logic [15:0] Logic_OUT;
  logic [15:0] CMP_OUT;
  logic [15:0] Shift_OUT;
  logic        Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
  logic        CLR;
  logic        RES_READY;
  logic        RES_VALID;
  logic [31:0] RES_DATA;
  logic [1:0]  RES_TAG;
  logic        RES_CARRY;
  logic [2:0]  RES_COUNT;
  logic        OVERFLOW;
  logic        MULTI_ERR;

  int checks = 0;
  int errors = 0;

  alu_result_collector dut (
    .CLK(CLK), .RST(RST),
    .Arith_OUT(Arith_OUT), .Carry_OUT(Carry_OUT), .Logic_OUT(Logic_OUT),
    .CMP_OUT(CMP_OUT), .Shift_OUT(Shift_OUT),
    .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag),
    .CLR(CLR), .RES_READY(RES_READY),
    .RES_VALID(RES_VALID), .RES_DATA(RES_DATA), .RES_TAG(RES_TAG), .RES_CARRY(RES_CARRY),
    .RES_COUNT(RES_COUNT), .OVERFLOW(OVERFLOW), .MULTI_ERR(MULTI_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    Arith_Flag = 1'b0; Logic_Flag = 1'b0; CMP_Flag = 1'b0; Shift_Flag = 1'b0;
    Carry_OUT  = 1'b0;
  endtask

  // Present one unit result for the coming edge; tag selects which unit.
  task automatic present(input logic [1:0] tag, input logic [31:0] val, input logic carry);
    idle();
    case (tag)
      2'b00: begin Arith_Flag = 1'b1; Arith_OUT = val; Carry_OUT = carry; end
      2'b01: begin Logic_Flag = 1'b1; Logic_OUT = val[15:0]; end
      2'b10: begin CMP_Flag   = 1'b1; CMP_OUT   = val[15:0]; end
      default: begin Shift_Flag = 1'b1; Shift_OUT = val[15:0]; end
    endcase
  endtask

  task automatic check_head(input string tag, input logic v, input logic [31:0] d,
                            input logic [1:0] t, input logic c, input logic [2:0] n);
    check_eq({tag, "_valid"}, 64'(RES_VALID), 64'(v));
    check_eq({tag, "_data"},  64'(RES_DATA),  64'(d));
    check_eq({tag, "_tag"},   64'(RES_TAG),   64'(t));
    check_eq({tag, "_carry"}, 64'(RES_CARRY), 64'(c));
    check_eq({tag, "_count"}, 64'(RES_COUNT), 64'(n));
  endtask

  initial begin
    RST = 1'b1; CLR = 1'b0; RES_READY = 1'b0;
    Arith_OUT = 32'h0; Logic_OUT = 16'h0; CMP_OUT = 16'h0; Shift_OUT = 16'h0;
    idle();
    step(); step();
    check_head("por", 1'b0, 32'h0, 2'b00, 1'b0, 3'd0);
    check_eq("por_ovf", 64'(OVERFLOW), 64'h0);
    check_eq("por_multi", 64'(MULTI_ERR), 64'h0);
    RST = 1'b0;
    step();

    // Single logic capture, then held with no consumer.
    present(2'b01, 32'h0000A5A5, 1'b0);
    step();
    idle();
    check_head("single", 1'b1, 32'h0000A5A5, 2'b01, 1'b0, 3'd1);
    step();
    check_head("single_hold", 1'b1, 32'h0000A5A5, 2'b01, 1'b0, 3'd1);

    // Fill to three entries, then assert reset between edges.
    present(2'b01, 32'h00000002, 1'b0); step();
    present(2'b01, 32'h00000003, 1'b0); step();
    idle();
    check_eq("three_count", 64'(RES_COUNT), 64'd3);
    #2 RST = 1'b1;
    #1;
    check_head("async_rst", 1'b0, 32'h0, 2'b00, 1'b0, 3'd0);
    check_eq("async_rst_multi", 64'(MULTI_ERR), 64'h0);
    present(2'b11, 32'h00000077, 1'b0);
    step();
    RST = 1'b0;
    idle();
    step();
    check_head("post_rst", 1'b0, 32'h0, 2'b00, 1'b0, 3'd0);

    // Ordering across pointer wrap with simultaneous push and pop.
    present(2'b00, 32'h00000001, 1'b1); step();
    check_head("ord1", 1'b1, 32'h1, 2'b00, 1'b1, 3'd1);
    present(2'b10, 32'h00000003, 1'b0); step();
    check_head("ord2", 1'b1, 32'h1, 2'b00, 1'b1, 3'd2);
    RES_READY = 1'b1;
    present(2'b11, 32'h00000008, 1'b0); step();
    check_head("ord3", 1'b1, 32'h3, 2'b10, 1'b0, 3'd2);
    present(2'b01, 32'h0000000F, 1'b0); step();
    check_head("ord4", 1'b1, 32'h8, 2'b11, 1'b0, 3'd2);
    present(2'b00, 32'h00000005, 1'b0); step();
    check_head("ord5", 1'b1, 32'hF, 2'b01, 1'b0, 3'd2);
    idle(); step();
    check_head("ord6", 1'b1, 32'h5, 2'b00, 1'b0, 3'd1);
    step();
    check_head("ord_empty", 1'b0, 32'h0, 2'b00, 1'b0, 3'd0);
    step();
    check_head("underflow", 1'b0, 32'h0, 2'b00, 1'b0, 3'd0);

    // Overflow: five shift pushes into a four-deep queue.
    RES_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      present(2'b11, 32'(17 + i), 1'b0);
      step();
      if (i == 3) check_eq("ovf_before", 64'(OVERFLOW), 64'h0);
    end
    idle();
    check_head("ovf_full", 1'b1, 32'd17, 2'b11, 1'b0, 3'd4);
    check_eq("ovf_set", 64'(OVERFLOW), 64'h1);
    present(2'b11, 32'd30, 1'b0);
    RES_READY = 1'b1;
    step();
    idle();
    check_head("full_pushpop", 1'b1, 32'd18, 2'b11, 1'b0, 3'd4);
    check_eq("ovf_sticky", 64'(OVERFLOW), 64'h1);
    step(); check_eq("drain1", 64'(RES_DATA), 64'd19);
    step(); check_eq("drain2", 64'(RES_DATA), 64'd20);
    step(); check_eq("drain3", 64'(RES_DATA), 64'd30);
    step();
    check_head("drained", 1'b0, 32'h0, 2'b00, 1'b0, 3'd0);
    check_eq("ovf_after_drain", 64'(OVERFLOW), 64'h1);

    // Multiple flags: nothing captured, sticky error until CLR.
    RES_READY = 1'b0;
    idle();
    Arith_Flag = 1'b1; CMP_Flag = 1'b1; Arith_OUT = 32'hDEAD; CMP_OUT = 16'hBEEF;
    step();
    idle();
    check_eq("multi_count", 64'(RES_COUNT), 64'd0);
    check_eq("multi_set", 64'(MULTI_ERR), 64'h1);
    present(2'b10, 32'h00000044, 1'b0); step();
    idle(); step();
    check_eq("multi_sticky", 64'(MULTI_ERR), 64'h1);
    check_eq("multi_then_push", 64'(RES_COUNT), 64'd1);
    CLR = 1'b1;
    present(2'b01, 32'h00000055, 1'b0);
    RES_READY = 1'b1;
    step();
    CLR = 1'b0; RES_READY = 1'b0;
    idle();
    check_head("clr", 1'b0, 32'h0, 2'b00, 1'b0, 3'd0);
    check_eq("clr_multi", 64'(MULTI_ERR), 64'h0);
    check_eq("clr_ovf", 64'(OVERFLOW), 64'h0);

    // Backpressure with READY toggling.
    present(2'b01, 32'h00000021, 1'b0); step();
    present(2'b01, 32'h00000022, 1'b0); step();
    idle();
    check_head("bp0", 1'b1, 32'h21, 2'b01, 1'b0, 3'd2);
    step();
    check_head("bp_stall1", 1'b1, 32'h21, 2'b01, 1'b0, 3'd2);
    RES_READY = 1'b1; step();
    check_head("bp_pop1", 1'b1, 32'h22, 2'b01, 1'b0, 3'd1);
    RES_READY = 1'b0; step();
    check_head("bp_stall2", 1'b1, 32'h22, 2'b01, 1'b0, 3'd1);
    RES_READY = 1'b1; step();
    check_head("bp_pop2", 1'b0, 32'h0, 2'b00, 1'b0, 3'd0);
    RES_READY = 1'b0; step();
    check_head("bp_end", 1'b0, 32'h0, 2'b00, 1'b0, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
